btn_toggle_bank: RTL and testbench
==================================

# btn_toggle_bank

Parametrised N-channel push-button front end. Each channel is synchronised, debounced, and edge-detected into a one-cycle press pulse that drives a per-channel state bit. A runtime mode selects between independent toggle behaviour and radio-button (one-hot) behaviour. Sits between the board buttons and the LED or control logic of a board design, replacing hand-instantiated edge-detector/toggle pairs.

## Interface
- `N`, default 3: number of button channels (1..16).
- `DB_CYCLES`, default 1250000: consecutive clock cycles a synchronised input must differ from its debounced value before the debounced value changes (10 ms at 125 MHz); minimum 1.
- `CNT_W`, default `$clog2(DB_CYCLES+1)`: debounce counter width, derived; never overridden.
- `sysclk` input 1: system clock; all state on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `mode` input 1: 0 = toggle mode, 1 = radio mode; sampled every cycle.
- `btn` input N: raw asynchronous button levels, 1 = pressed.
- `stable` output N: debounced button levels.
- `press` output N: one-cycle pulse per debounced rising edge.
- `state` output N: channel state bits (LED drive).
- `press_count` output 8: count of cycles with at least one press; wraps.

## Operation
- Per channel, `btn[i]` passes through a 2-FF synchroniser (s1, s2).
- Debounce per channel, with counter `cnt` and register `stable[i]`:
  - s2 == stable[i]: cnt <= 0.
  - s2 != stable[i] and cnt < DB_CYCLES-1: cnt <= cnt+1.
  - s2 != stable[i] and cnt == DB_CYCLES-1: stable[i] <= s2, cnt <= 0.
  - Any cycle where s2 returns to stable[i] restarts the count. Glitches shorter than DB_CYCLES synchronised cycles are rejected.
- Press: registered. `press[i]` <= 1 on the edge where stable[i] goes 0→1; otherwise 0. Falling transitions of stable produce no pulse.
- `mode_q`: registered copy of `mode`.
- State update, in priority order:
  1. If mode != mode_q, state <= 0 and presses in that cycle are ignored.
  2. Toggle mode (mode_q = 0): state <= state ^ press. Simultaneous presses toggle independently.
  3. Radio mode (mode_q = 1): if press != 0, state <= one-hot of the lowest-index asserted press bit. Pressing the already-selected channel leaves it selected. If press == 0, state holds.
- `press_count` <= press_count + 1 (mod 256) on each cycle with press != 0. Simultaneous presses count once.

## Timing
- Reset: s1, s2, cnt, stable, press, state, mode_q, and press_count all clear to 0 asynchronously.
- Reset mid-debounce discards partial counts. A button held through reset release is re-debounced from scratch and yields one press DB_CYCLES+2 edges after release.
- Latency, with btn[i] rising before clock edge E0 (first sampling edge):
  - s2 = 1 after E0+1.
  - stable[i] = 1 after edge E0+1+DB_CYCLES.
  - press[i] high from that same edge for exactly one cycle.
  - state[i] updates at edge E0+2+DB_CYCLES.
  - press_count updates at edge E0+2+DB_CYCLES.
- Release latency is identical for stable; press stays 0.
- Mode change: state clears at the edge after `mode` changes, i.e. the first edge where mode != mode_q. A press landing in that cycle is lost.
- press_count wraps from 255 to 0.

## Test plan
All scenarios use N=3, DB_CYCLES=4.
- Reset: assert reset mid-cycle with btn=3'b111 → all outputs 0 immediately, with no clock edge needed. Release reset with btn held → exactly one press per channel 6 edges later, state=3'b111.
- Debounce: btn[0] high for 3 cycles then low → stable, press, and state stay 0. btn[0] held 10 cycles → stable[0] rises at edge E0+5, press[0] is a single one-cycle pulse, state[0]=1 at E0+6.
- Toggle: two separated debounced presses on btn[1] in mode 0 → state[1] goes 0→1→0. Releases produce no press. press_count=2.
- Radio: mode=1 (state cleared), press btn[2] → state=3'b100. Press btn[0] and btn[1] simultaneously → state=3'b001, press_count increments by 1. Press btn[0] again → state stays 3'b001.
- Mode switch: state=3'b101 in mode 0, set mode=1 → state=3'b000 on the next edge. A press coincident with that edge is ignored.
- Wrap: 257 separated presses → press_count=1.

Source files
------------

// File: rtl/btn_toggle_bank_if.sv
// Button bank bus: raw buttons and mode in, debounced levels, pulses and state out.
interface btn_toggle_bank_if #(
  parameter int unsigned N = 3
);
  logic         mode;
  logic [N-1:0] btn;
  logic [N-1:0] stable;
  logic [N-1:0] press;
  logic [N-1:0] state;
  logic [7:0]   press_count;

  // Board-side driver of buttons and mode
  modport master (
    output mode, btn,
    input  stable, press, state, press_count
  );

  // The button bank itself
  modport slave (
    input  mode, btn,
    output stable, press, state, press_count
  );
endinterface

// File: rtl/btn_toggle_bank.sv
// N-channel push-button front end: synchronise, debounce, rising-edge detect,
// then drive per-channel state bits in toggle or radio (one-hot) mode.
module btn_toggle_bank #(
  parameter int unsigned N         = 3,
  parameter int unsigned DB_CYCLES = 1250000,
  parameter int unsigned CNT_W     = $clog2(DB_CYCLES + 1)
) (
  input  logic             sysclk,
  input  logic             reset,
  btn_toggle_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [N-1:0]     s1;
  logic [N-1:0]     s2;
  logic [CNT_W-1:0] cnt [N];
  logic [N-1:0]     stable_q;
  logic [N-1:0]     press_q;
  logic [N-1:0]     state_q;
  logic             mode_q;
  logic [7:0]       count_q;

  logic [N-1:0]     rise_c;
  logic [N-1:0]     lowest_c;

  // Two-flop synchroniser for the asynchronous button levels
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn;
      s2 <= s1;
    end
  end

  // Channels whose debounced level commits 0->1 on the coming edge
  always_comb begin
    rise_c = '0;
    for (int i = 0; i < int'(N); i++) begin
      rise_c[i] = s2[i] & ~stable_q[i] & (cnt[i] == CNT_LAST);
    end
  end

  // Lowest-index asserted press bit as a one-hot vector
  always_comb begin
    lowest_c = '0;
    lowest_c = press_q & (~press_q + N'(1));
  end

  // Debounce counters, debounced levels and registered press pulses
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N); i++) begin
        cnt[i] <= '0;
      end
      stable_q <= '0;
      press_q  <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (s2[i] == stable_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable_q[i] <= s2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      press_q <= rise_c;
    end
  end

  // Mode tracking, state update (mode change wins) and press-cycle counter
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      mode_q  <= 1'b0;
      state_q <= '0;
      count_q <= '0;
    end else begin
      mode_q <= bus.mode;
      if (bus.mode != mode_q) begin
        state_q <= '0;
      end else if (!mode_q) begin
        state_q <= state_q ^ press_q;
      end else if (press_q != '0) begin
        state_q <= lowest_c;
      end
      if (press_q != '0) begin
        count_q <= count_q + 8'd1;
      end
    end
  end

  assign bus.stable      = stable_q;
  assign bus.press       = press_q;
  assign bus.state       = state_q;
  assign bus.press_count = count_q;

endmodule

// File: tb/tb_btn_toggle_bank.sv
// Scoreboard bench for btn_toggle_bank (N=3, DB_CYCLES=4).
module tb_btn_toggle_bank;

  localparam int unsigned N  = 3;
  localparam int unsigned DB = 4;

  typedef struct packed {
    logic [N-1:0] stable;
    logic [N-1:0] press;
    logic [N-1:0] state;
    logic [7:0]   cnt;
  } obs_t;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  btn_toggle_bank_if #(.N(N)) bus ();

  btn_toggle_bank #(
    .N(N),
    .DB_CYCLES(DB)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int passes = 0;

  obs_t exp_q[$];

  // Reference model state: raw samples of btn taken at each edge since reset
  logic [N-1:0] samp[$];
  logic [N-1:0] m_stable, m_press, m_state, nxt_press, smp_v;
  logic         m_mode_q;
  logic [7:0]   m_cnt;

  // btn level captured at edge j (1-based since reset); before that, zero
  function automatic logic [N-1:0] smp(int j);
    if (j >= 1 && j <= samp.size()) return samp[j-1];
    return '0;
  endfunction

  // Behavioural model: a channel's debounced level flips once the last DB
  // synchronised samples all disagree with it; outputs pushed per edge.
  always @(posedge sysclk or posedge reset) begin
    if (reset) begin
      samp.delete();
      exp_q.delete();
      m_stable = '0;
      m_press  = '0;
      m_state  = '0;
      m_mode_q = 1'b0;
      m_cnt    = '0;
    end else begin
      int k;
      bit all_diff;
      samp.push_back(bus.btn);
      k = samp.size();
      nxt_press = '0;
      for (int i = 0; i < int'(N); i++) begin
        all_diff = 1'b1;
        for (int j = k - int'(DB) - 1; j <= k - 2; j++) begin
          smp_v = smp(j);
          if (smp_v[i] == m_stable[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_stable[i]  = ~m_stable[i];
          nxt_press[i] = m_stable[i];
        end
      end
      if (bus.mode != m_mode_q) begin
        m_state = '0;
      end else if (!m_mode_q) begin
        m_state = m_state ^ m_press;
      end else if (m_press != '0) begin
        int low;
        low = 0;
        for (int i = int'(N) - 1; i >= 0; i--) if (m_press[i]) low = i;
        m_state = '0;
        m_state[low] = 1'b1;
      end
      if (m_press != '0) m_cnt = m_cnt + 8'd1;
      m_mode_q = bus.mode;
      m_press  = nxt_press;
      exp_q.push_back('{stable: m_stable, press: m_press, state: m_state, cnt: m_cnt});
    end
  end

  // Monitor: compare DUT outputs after every edge against queued expectations
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge sysclk);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{stable: bus.stable, press: bus.press, state: bus.state, cnt: bus.press_count};
        checks++;
        if (a == e) passes++;
        else $display("FAIL scoreboard t=%0t got stable=%b press=%b state=%b cnt=%0d expected stable=%b press=%b state=%b cnt=%0d",
                      $time, a.stable, a.press, a.state, a.cnt, e.stable, e.press, e.state, e.cnt);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic do_reset();
    @(negedge sysclk);
    #2 reset = 1'b1;
    @(negedge sysclk);
    reset = 1'b0;
  endtask

  task automatic press_btn(input logic [N-1:0] mask, input int hold);
    bus.btn = mask;
    tick(hold);
    bus.btn = '0;
    tick(8);
  endtask

  initial begin
    int c0;
    bus.btn  = '0;
    bus.mode = 1'b0;
    tick(2);
    reset = 1'b0;

    // Async reset mid-cycle with all buttons held, then release with them held
    bus.btn = 3'b111;
    tick(8);
    @(negedge sysclk);
    #2 reset = 1'b1;
    #1;
    chk("rst_stable", int'(bus.stable), 0);
    chk("rst_press", int'(bus.press), 0);
    chk("rst_state", int'(bus.state), 0);
    chk("rst_count", int'(bus.press_count), 0);
    @(negedge sysclk);
    reset = 1'b0;
    tick(10);
    chk("held_thru_reset_state", int'(bus.state), 7);
    chk("held_thru_reset_count", int'(bus.press_count), 1);
    bus.btn = '0;
    tick(8);

    // Glitch rejection, then a real press
    do_reset();
    bus.btn = 3'b001;
    tick(3);
    bus.btn = '0;
    tick(10);
    chk("glitch_stable", int'(bus.stable), 0);
    chk("glitch_state", int'(bus.state), 0);
    chk("glitch_count", int'(bus.press_count), 0);
    press_btn(3'b001, 10);
    chk("held_state", int'(bus.state), 1);

    // Toggle mode
    do_reset();
    press_btn(3'b010, 8);
    chk("toggle_on", int'(bus.state), 2);
    press_btn(3'b010, 8);
    chk("toggle_off", int'(bus.state), 0);
    chk("toggle_count", int'(bus.press_count), 2);

    // Radio mode
    do_reset();
    bus.mode = 1'b1;
    tick(3);
    press_btn(3'b100, 8);
    chk("radio_ch2", int'(bus.state), 4);
    c0 = int'(bus.press_count);
    press_btn(3'b011, 8);
    chk("radio_lowest", int'(bus.state), 1);
    chk("radio_simul_count", int'(bus.press_count), (c0 + 1) % 256);
    press_btn(3'b001, 8);
    chk("radio_reselect", int'(bus.state), 1);

    // Mode switch clears state; a coincident press is lost
    do_reset();
    bus.mode = 1'b0;
    press_btn(3'b101, 8);
    chk("pre_switch_state", int'(bus.state), 5);
    bus.mode = 1'b1;
    @(posedge sysclk);
    #1;
    chk("switch_clear", int'(bus.state), 0);
    @(negedge sysclk);
    bus.mode = 1'b0;
    tick(3);
    c0 = int'(bus.press_count);
    bus.btn = 3'b010;
    tick(6);
    bus.mode = 1'b1;
    @(posedge sysclk);
    #1;
    chk("coincident_lost", int'(bus.state), 0);
    chk("coincident_counted", int'(bus.press_count), (c0 + 1) % 256);
    @(negedge sysclk);
    bus.btn = '0;
    tick(8);
    chk("coincident_stays", int'(bus.state), 0);

    // press_count wrap
    do_reset();
    bus.mode = 1'b0;
    tick(2);
    repeat (257) press_btn(3'b001, 6);
    chk("wrap_count", int'(bus.press_count), 1);
    chk("wrap_state", int'(bus.state), 1);

    // Randomised levels and mode flips, checked by the scoreboard
    do_reset();
    repeat (400) begin
      bus.btn = N'($urandom);
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      tick(int'($urandom_range(1, 10)));
    end
    bus.btn = '0;
    tick(12);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
